// File: rtl/ucsbece154a_memarb.sv
// Round-robin arbiter sharing one single-ported memory between fetch and load/store.
// One registered access per 3 cycles; bad addresses are flagged instead of accessed.
module ucsbece154a_memarb #(
    parameter logic [31:0] TEXT_START = 32'h00400000,
    parameter int unsigned TEXT_SIZE  = 64,
    parameter logic [31:0] DATA_START = 32'h10000000,
    parameter int unsigned DATA_SIZE  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_i,
    input  logic [31:0] i_a_i,
    output logic        i_ack_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_a_i,
    input  logic [31:0] d_wd_i,
    output logic        d_ack_o,
    output logic [31:0] rd_o,
    output logic        err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_a_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam logic [31:0] TEXT_END = TEXT_START + 32'(4 * TEXT_SIZE);
    localparam logic [31:0] DATA_END = DATA_START + 32'(4 * DATA_SIZE);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nx;
    logic        last_d;
    logic        own_d;
    logic        we_q;
    logic        err_q;
    logic        req_any;
    logic        grant_d;
    logic        req_we;
    logic        in_text;
    logic        in_data;
    logic        a_err;
    logic [31:0] req_a;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_any) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // last_d set means data won last, so a tie goes to fetch
    always_comb begin
        req_any = i_req_i | d_req_i;
        grant_d = d_req_i & (~i_req_i | ~last_d);
        req_a   = grant_d ? d_a_i : i_a_i;
        req_we  = grant_d & d_we_i;
        in_text = (req_a >= TEXT_START) && (req_a < TEXT_END);
        in_data = (req_a >= DATA_START) && (req_a < DATA_END);
        a_err   = (req_a[1:0] != 2'b00)
                | ~(in_text | in_data)
                | (req_we & ~in_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_d   <= 1'b1;
            own_d    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            mem_a_o  <= '0;
            mem_wd_o <= '0;
            rd_o     <= '0;
            err_o    <= 1'b0;
        end else begin
            if (state == IDLE && req_any) begin
                own_d    <= grant_d;
                last_d   <= grant_d;
                mem_a_o  <= req_a;
                we_q     <= req_we;
                mem_wd_o <= grant_d ? d_wd_i : 32'h0;
                err_q    <= a_err;
            end
            if (state == ACCESS) begin
                rd_o  <= (we_q | err_q) ? 32'h0 : mem_rd_i;
                err_o <= err_q;
            end
        end
    end

    always_comb begin
        mem_we_o = (state == ACCESS) & we_q & ~err_q & ~reset;
        i_ack_o  = (state == RESP) & ~own_d & ~reset;
        d_ack_o  = (state == RESP) & own_d & ~reset;
    end

endmodule
